// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_e;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   localparam int unsigned           AGE_W   = 4;
   localparam logic [AGE_W-1:0]      AGE_MAX = 4'd15;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the synchronous-read memory port.
interface dmem_arbiter_if #(
   parameter int unsigned AW = 32
) ();

   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_wdata;
   logic [3:0]    cpu_we;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [31:0]   cpu_rdata;

   logic          dma_req;
   logic [AW-1:0] dma_addr;
   logic [31:0]   dma_wdata;
   logic [3:0]    dma_we;
   logic          dma_gnt;
   logic          dma_rvalid;
   logic [31:0]   dma_rdata;

   logic [AW-1:0] daddr;
   logic [31:0]   dwdata;
   logic [3:0]    dwe;
   logic          dre;
   logic [31:0]   drdata;

   // Arbiter side.
   modport slave (
      input  cpu_req, cpu_addr, cpu_wdata, cpu_we,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_addr, dma_wdata, dma_we,
      output dma_gnt, dma_rvalid, dma_rdata,
      output daddr, dwdata, dwe, dre,
      input  drdata
   );

   // Requesters and memory side.
   modport master (
      output cpu_req, cpu_addr, cpu_wdata, cpu_we,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dma_req, dma_addr, dma_wdata, dma_we,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  daddr, dwdata, dwe, dre,
      output drdata
   );

endinterface

// File: rtl/dmem_arbiter_age_ctr.sv
// Saturating DMA starvation counter; o_force requests a DMA win once age reaches MAX_WAIT.
module arb_age_ctr
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_force
);

   logic [AGE_W-1:0] r_age;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_age <= '0;
      end else if (i_clr) begin
         r_age <= '0;
      end else if (i_inc && (r_age != AGE_MAX)) begin
         r_age <= r_age + 1'b1;
      end
   end

   assign o_force = (32'(r_age) >= MAX_WAIT);

endmodule

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter for the single data-memory port: IDLE -> ISSUE -> RESP, where RESP
// doubles as the accept point of the next transaction.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW       = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   arb_state_e    r_state;
   arb_state_e    w_state_nxt;

   logic          r_owner;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_we;

   logic          w_accept;
   logic          w_cpu_win;
   logic          w_dma_win;
   logic          w_force;
   logic          w_age_inc;
   logic          w_age_clr;
   logic          w_issue;
   logic          w_resp;
   logic          w_load;

   arb_age_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_age_ctr (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_age_inc),
      .i_clr   (w_age_clr),
      .o_force (w_force)
   );

   always_comb begin
      w_accept  = (r_state != ST_ISSUE);
      w_dma_win = w_accept & bus.dma_req & (~bus.cpu_req | w_force);
      w_cpu_win = w_accept & bus.cpu_req & ~w_dma_win;
      // DMA only ages when it actually competed at an accept point and lost.
      w_age_inc = w_cpu_win & bus.dma_req;
      w_age_clr = w_dma_win;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE,
         ST_RESP:  w_state_nxt = (w_cpu_win | w_dma_win) ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: w_state_nxt = ST_RESP;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_owner <= OWN_CPU;
         r_addr  <= '0;
         r_wdata <= '0;
         r_we    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_dma_win) begin
            r_owner <= OWN_DMA;
            r_addr  <= bus.dma_addr;
            r_wdata <= bus.dma_wdata;
            r_we    <= bus.dma_we;
         end else if (w_cpu_win) begin
            r_owner <= OWN_CPU;
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_wdata;
            r_we    <= bus.cpu_we;
         end
      end
   end

   // r_we still describes the in-flight access during RESP; it only reloads on the next edge.
   always_comb begin
      w_issue = (r_state == ST_ISSUE);
      w_resp  = (r_state == ST_RESP);
      w_load  = (r_we == 4'h0);

      bus.cpu_gnt    = w_cpu_win;
      bus.dma_gnt    = w_dma_win;

      bus.daddr      = r_addr;
      bus.dwdata     = r_wdata;
      bus.dwe        = w_issue ? r_we : 4'h0;
      bus.dre        = w_issue & w_load;

      bus.cpu_rvalid = w_resp & (r_owner == OWN_CPU);
      bus.dma_rvalid = w_resp & (r_owner == OWN_DMA);
      bus.cpu_rdata  = (bus.cpu_rvalid & w_load) ? bus.drdata : 32'h0;
      bus.dma_rdata  = (bus.dma_rvalid & w_load) ? bus.drdata : 32'h0;
   end

endmodule
